// File: rtl/i2c_ball_slave_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_ball_slave_rx_if
// Brief    : I2C bus lines seen by the ball-link slave receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_ball_slave_rx_if;
    logic scl;
    logic sda_in;
    logic sda_oe;

    modport master (output scl, output sda_in, input sda_oe);
    modport slave  (input scl, input sda_in, output sda_oe);
endinterface
`default_nettype wire

// File: rtl/i2c_ball_slave_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2c_ball_slave_rx
// Brief    : I2C write-only slave that decodes the 6-byte ball-state frame
//            and commits it atomically on STOP.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_ball_slave_rx #(
    parameter logic [7:0]  ADDR_BYTE = 8'hAA,
    parameter int unsigned N_DATA    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    i2c_ball_slave_rx_if.slave    bus,
    output logic [9:0]            ball_y,
    output logic [7:0]            ball_vy,
    output logic [1:0]            gravity_counter,
    output logic                  is_collusion,
    output logic                  packet_valid,
    output logic                  frame_error,
    output logic                  busy,
    output logic [7:0]            intf_led
);
    localparam int unsigned         c_cnt_w  = $clog2(N_DATA + 1);
    localparam logic [c_cnt_w-1:0]  c_n_data = c_cnt_w'(N_DATA);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_DATA, ST_DATA_ACK, ST_IGNORE
    } state_t;

    state_t               r_state, w_state_nx;
    logic [2:0]           r_scl_sync, r_sda_sync;
    logic [3:0]           r_bit_cnt, w_bit_cnt_nx;
    logic [c_cnt_w-1:0]   r_byte_cnt, w_byte_cnt_nx;
    logic [7:0]           r_shift, w_shift_nx;
    logic [1:0]           r_sh_y_hi, w_sh_y_hi_nx;
    logic [7:0]           r_sh_y_lo, w_sh_y_lo_nx;
    logic [7:0]           r_sh_vy, w_sh_vy_nx;
    logic [1:0]           r_sh_grav, w_sh_grav_nx;
    logic                 r_sh_coll, w_sh_coll_nx;
    logic                 r_overrun, w_overrun_nx;
    logic                 r_busy, w_busy_nx;
    logic                 r_sda_oe, w_sda_oe_nx;
    logic [9:0]           r_ball_y, w_ball_y_nx;
    logic [7:0]           r_ball_vy, w_ball_vy_nx;
    logic [1:0]           r_grav, w_grav_nx;
    logic                 r_coll, w_coll_nx;
    logic                 r_pv, w_pv_nx;
    logic                 r_fe, w_fe_nx;

    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    // Synchronisers idle at 1 so reset release on an idle bus creates no edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_sync <= 3'b111;
            r_sda_sync <= 3'b111;
        end else begin
            r_scl_sync <= {r_scl_sync[1:0], bus.scl};
            r_sda_sync <= {r_sda_sync[1:0], bus.sda_in};
        end
    end

    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign w_scl_rise = w_scl & ~r_scl_sync[2];
    assign w_scl_fall = ~w_scl & r_scl_sync[2];
    assign w_start    = w_scl & r_sda_sync[2] & ~w_sda;
    assign w_stop     = w_scl & ~r_sda_sync[2] & w_sda;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_sh_y_hi  <= '0;
            r_sh_y_lo  <= '0;
            r_sh_vy    <= '0;
            r_sh_grav  <= '0;
            r_sh_coll  <= 1'b0;
            r_overrun  <= 1'b0;
            r_busy     <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_ball_y   <= '0;
            r_ball_vy  <= '0;
            r_grav     <= '0;
            r_coll     <= 1'b0;
            r_pv       <= 1'b0;
            r_fe       <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_byte_cnt <= w_byte_cnt_nx;
            r_shift    <= w_shift_nx;
            r_sh_y_hi  <= w_sh_y_hi_nx;
            r_sh_y_lo  <= w_sh_y_lo_nx;
            r_sh_vy    <= w_sh_vy_nx;
            r_sh_grav  <= w_sh_grav_nx;
            r_sh_coll  <= w_sh_coll_nx;
            r_overrun  <= w_overrun_nx;
            r_busy     <= w_busy_nx;
            r_sda_oe   <= w_sda_oe_nx;
            r_ball_y   <= w_ball_y_nx;
            r_ball_vy  <= w_ball_vy_nx;
            r_grav     <= w_grav_nx;
            r_coll     <= w_coll_nx;
            r_pv       <= w_pv_nx;
            r_fe       <= w_fe_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_bit_cnt_nx  = r_bit_cnt;
        w_byte_cnt_nx = r_byte_cnt;
        w_shift_nx    = r_shift;
        w_sh_y_hi_nx  = r_sh_y_hi;
        w_sh_y_lo_nx  = r_sh_y_lo;
        w_sh_vy_nx    = r_sh_vy;
        w_sh_grav_nx  = r_sh_grav;
        w_sh_coll_nx  = r_sh_coll;
        w_overrun_nx  = r_overrun;
        w_busy_nx     = r_busy;
        w_sda_oe_nx   = r_sda_oe;
        w_ball_y_nx   = r_ball_y;
        w_ball_vy_nx  = r_ball_vy;
        w_grav_nx     = r_grav;
        w_coll_nx     = r_coll;
        w_pv_nx       = 1'b0;
        w_fe_nx       = 1'b0;

        if (w_start) begin
            w_state_nx    = ST_ADDR;
            w_bit_cnt_nx  = '0;
            w_byte_cnt_nx = '0;
            w_sh_y_hi_nx  = '0;
            w_sh_y_lo_nx  = '0;
            w_sh_vy_nx    = '0;
            w_sh_grav_nx  = '0;
            w_sh_coll_nx  = 1'b0;
            w_overrun_nx  = 1'b0;
            w_sda_oe_nx   = 1'b0;
            w_busy_nx     = 1'b0;
            w_fe_nx       = r_busy;
        end else if (w_stop) begin
            w_state_nx  = ST_IDLE;
            w_sda_oe_nx = 1'b0;
            w_busy_nx   = 1'b0;
            if (r_busy) begin
                if (r_byte_cnt == c_n_data && !r_overrun) begin
                    w_ball_y_nx  = {r_sh_y_hi, r_sh_y_lo};
                    w_ball_vy_nx = r_sh_vy;
                    w_grav_nx    = r_sh_grav;
                    w_coll_nx    = r_sh_coll;
                    w_pv_nx      = 1'b1;
                end else begin
                    w_fe_nx = 1'b1;
                end
            end
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nx   = {r_shift[6:0], w_sda};
                        w_bit_cnt_nx = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        if (r_shift == ADDR_BYTE) begin
                            w_state_nx  = ST_ADDR_ACK;
                            w_sda_oe_nx = 1'b1;
                            w_busy_nx   = 1'b1;
                        end else begin
                            w_state_nx = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK, ST_DATA_ACK: begin
                    // Entry happens on a fall, so the next fall closes the ACK clock
                    if (w_scl_fall) begin
                        w_state_nx   = ST_DATA;
                        w_sda_oe_nx  = 1'b0;
                        w_bit_cnt_nx = '0;
                    end
                end
                ST_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nx   = {r_shift[6:0], w_sda};
                        w_bit_cnt_nx = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        if (r_byte_cnt < c_n_data) begin
                            case (r_byte_cnt)
                                c_cnt_w'(0): w_sh_y_hi_nx = r_shift[7:6];
                                c_cnt_w'(1): w_sh_y_lo_nx = r_shift;
                                c_cnt_w'(2): w_sh_vy_nx   = r_shift;
                                c_cnt_w'(3): w_sh_grav_nx = r_shift[1:0];
                                default:     w_sh_coll_nx = r_shift[0];
                            endcase
                            w_byte_cnt_nx = r_byte_cnt + c_cnt_w'(1);
                            w_state_nx    = ST_DATA_ACK;
                            w_sda_oe_nx   = 1'b1;
                        end else begin
                            w_overrun_nx = 1'b1;
                            w_state_nx   = ST_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (r_state)
            ST_ADDR:     intf_led = 8'h01;
            ST_ADDR_ACK: intf_led = 8'h02;
            ST_DATA:     intf_led = 8'h04;
            ST_DATA_ACK: intf_led = 8'h08;
            ST_IGNORE:   intf_led = 8'h10;
            default:     intf_led = 8'h00;
        endcase
    end

    assign bus.sda_oe      = r_sda_oe;
    assign ball_y          = r_ball_y;
    assign ball_vy         = r_ball_vy;
    assign gravity_counter = r_grav;
    assign is_collusion    = r_coll;
    assign packet_valid    = r_pv;
    assign frame_error     = r_fe;
    assign busy            = r_busy;
endmodule
`default_nettype wire
